// File: rtl/controle_busca.sv
// Fetch sequencer and PC register: fetches over a req/ready handshake, presents each
// instruction for one execute cycle, and supports halt/resume plus a fetch-timeout trap.
module controle_busca #(
    parameter logic [31:0] PC_INICIAL = 32'h0000_0000,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] novo_PC,
    input  logic        halt,
    input  logic        continuar,
    input  logic        mem_pronto,
    input  logic [31:0] mem_dado,
    output logic [31:0] PC,
    output logic [31:0] mem_endereco,
    output logic        mem_req,
    output logic [31:0] instrucao,
    output logic        executa,
    output logic        parado,
    output logic        erro,
    output logic [31:0] instr_contador
);

    localparam int unsigned W_DADO   = 32;
    localparam int unsigned W_ESPERA = 16;
    localparam logic [W_ESPERA-1:0] LIMITE = W_ESPERA'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        BUSCA   = 2'd0,
        EXECUTA = 2'd1,
        PARADO  = 2'd2,
        ERRO    = 2'd3
    } estado_t;

    estado_t             r_estado;
    estado_t             w_prox_estado;
    logic [W_DADO-1:0]   r_pc;
    logic [W_DADO-1:0]   r_instrucao;
    logic [W_DADO-1:0]   r_contador;
    logic [W_ESPERA-1:0] r_espera;
    logic                r_mem_req;
    logic                r_executa;
    logic                r_parado;
    logic                r_erro;

    // Next-state decode
    always_comb begin
        w_prox_estado = r_estado;
        case (r_estado)
            BUSCA: begin
                if (mem_pronto)
                    w_prox_estado = EXECUTA;
                else if (r_espera == LIMITE)
                    w_prox_estado = ERRO;
            end
            EXECUTA: w_prox_estado = halt ? PARADO : BUSCA;
            PARADO: begin
                if (continuar)
                    w_prox_estado = BUSCA;
            end
            ERRO:    w_prox_estado = ERRO;
            default: w_prox_estado = BUSCA;
        endcase
    end

    // State, datapath and registered Moore flags (flags track the state being entered)
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_estado    <= BUSCA;
            r_pc        <= PC_INICIAL;
            r_instrucao <= '0;
            r_contador  <= '0;
            r_espera    <= '0;
            r_mem_req   <= 1'b1;
            r_executa   <= 1'b0;
            r_parado    <= 1'b0;
            r_erro      <= 1'b0;
        end else begin
            r_estado  <= w_prox_estado;
            r_mem_req <= (w_prox_estado == BUSCA);
            r_executa <= (w_prox_estado == EXECUTA);
            r_parado  <= (w_prox_estado == PARADO);
            r_erro    <= (w_prox_estado == ERRO);
            case (r_estado)
                BUSCA: begin
                    if (mem_pronto) begin
                        r_instrucao <= mem_dado;
                        r_espera    <= '0;
                    end else if (r_espera != LIMITE) begin
                        r_espera <= r_espera + W_ESPERA'(1);
                    end
                end
                EXECUTA: begin
                    r_pc       <= novo_PC;
                    r_contador <= r_contador + W_DADO'(1);
                end
                PARADO: begin
                    if (continuar)
                        r_espera <= '0;
                end
                default: ;
            endcase
        end
    end

    assign PC             = r_pc;
    assign mem_endereco   = r_pc;
    assign instrucao      = r_instrucao;
    assign instr_contador = r_contador;
    assign mem_req        = r_mem_req;
    assign executa        = r_executa;
    assign parado         = r_parado;
    assign erro           = r_erro;

endmodule

// File: tb/tb_controle_busca.sv
// Bench for controle_busca: vector table replayed through a scoreboard queue, plus
// hand-written timeout sequences.
module tb_controle_busca;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] novo_PC;
    logic        halt;
    logic        continuar;
    logic        mem_pronto;
    logic [31:0] mem_dado;
    logic [31:0] PC;
    logic [31:0] mem_endereco;
    logic        mem_req;
    logic [31:0] instrucao;
    logic        executa;
    logic        parado;
    logic        erro;
    logic [31:0] instr_contador;

    int n_vec  = 0;
    int n_erro = 0;

    controle_busca #(.PC_INICIAL(32'h10), .TIMEOUT(4)) dut (
        .clock(clock), .reset(reset), .novo_PC(novo_PC), .halt(halt),
        .continuar(continuar), .mem_pronto(mem_pronto), .mem_dado(mem_dado),
        .PC(PC), .mem_endereco(mem_endereco), .mem_req(mem_req),
        .instrucao(instrucao), .executa(executa), .parado(parado), .erro(erro),
        .instr_contador(instr_contador)
    );

    always #5 clock = ~clock;

    // flags = {mem_req, executa, parado, erro}
    typedef struct {
        logic        rst;
        logic        pr;
        logic [31:0] dado;
        logic [31:0] npc;
        logic        hlt;
        logic        cont;
        logic [3:0]  flags;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] cnt;
    } vec_t;

    vec_t tabela[$];
    vec_t esperado[$];

    task automatic v(input logic rst, input logic pr, input logic [31:0] dado,
                     input logic [31:0] npc, input logic hlt, input logic cont,
                     input logic [3:0] flags, input logic [31:0] pc,
                     input logic [31:0] inst, input logic [31:0] cnt);
        vec_t t;
        t.rst = rst; t.pr = pr; t.dado = dado; t.npc = npc; t.hlt = hlt; t.cont = cont;
        t.flags = flags; t.pc = pc; t.inst = inst; t.cnt = cnt;
        tabela.push_back(t);
    endtask

    task automatic drive(input vec_t t);
        reset = t.rst; mem_pronto = t.pr; mem_dado = t.dado;
        novo_PC = t.npc; halt = t.hlt; continuar = t.cont;
    endtask

    task automatic compara(input string nome, input vec_t e);
        logic [3:0] f;
        f = {mem_req, executa, parado, erro};
        n_vec++;
        if (f !== e.flags || PC !== e.pc || mem_endereco !== e.pc ||
            instrucao !== e.inst || instr_contador !== e.cnt) begin
            n_erro++;
            $display("FAIL %s: got flags=%b PC=%h addr=%h instr=%h cnt=%0d, want flags=%b PC=%h instr=%h cnt=%0d",
                     nome, f, PC, mem_endereco, instrucao, instr_contador,
                     e.flags, e.pc, e.inst, e.cnt);
        end
    endtask

    task automatic ciclo(input vec_t t, input string nome);
        vec_t e;
        @(negedge clock);
        drive(t);
        esperado.push_back(t);
        @(posedge clock);
        #1;
        e = esperado.pop_front();
        compara(nome, e);
    endtask

    initial begin
        vec_t t;
        int   espera;
        reset = 1'b0; mem_pronto = 1'b0; mem_dado = '0; novo_PC = '0;
        halt = 1'b0; continuar = 1'b0;

        //  rst pr dado           npc            h  c  flags    pc             inst           cnt
        v(0, 0, 32'h0,         32'h0,         0, 0, 4'b1000, 32'h10, 32'h0,         0);
        v(0, 0, 32'h0,         32'h0,         0, 0, 4'b1000, 32'h10, 32'h0,         0);
        v(1, 1, 32'hA,         32'h0,         0, 0, 4'b0100, 32'h10, 32'hA,         0);
        v(1, 1, 32'hA,         32'h11,        0, 0, 4'b1000, 32'h11, 32'hA,         1);
        v(1, 1, 32'hA,         32'h0,         0, 0, 4'b0100, 32'h11, 32'hA,         1);
        v(1, 1, 32'hA,         32'h12,        0, 0, 4'b1000, 32'h12, 32'hA,         2);
        v(1, 1, 32'hA,         32'h0,         0, 0, 4'b0100, 32'h12, 32'hA,         2);
        v(1, 1, 32'hA,         32'h13,        0, 0, 4'b1000, 32'h13, 32'hA,         3);
        // three wait cycles, ready in the 4th BUSCA cycle (timeout boundary, ready wins)
        v(1, 0, 32'h0,         32'h0,         0, 0, 4'b1000, 32'h13, 32'hA,         3);
        v(1, 0, 32'h0,         32'h0,         0, 0, 4'b1000, 32'h13, 32'hA,         3);
        v(1, 0, 32'h0,         32'h0,         0, 0, 4'b1000, 32'h13, 32'hA,         3);
        v(1, 1, 32'hDEAD_BEEF, 32'h55,        0, 0, 4'b0100, 32'h13, 32'hDEAD_BEEF, 3);
        // halt, five stable halted cycles with stray inputs, then resume
        v(1, 1, 32'h1,         32'h20,        1, 0, 4'b0010, 32'h20, 32'hDEAD_BEEF, 4);
        v(1, 1, 32'h2,         32'h30,        1, 0, 4'b0010, 32'h20, 32'hDEAD_BEEF, 4);
        v(1, 1, 32'h3,         32'h30,        1, 0, 4'b0010, 32'h20, 32'hDEAD_BEEF, 4);
        v(1, 1, 32'h4,         32'h30,        0, 0, 4'b0010, 32'h20, 32'hDEAD_BEEF, 4);
        v(1, 0, 32'h4,         32'h30,        0, 0, 4'b0010, 32'h20, 32'hDEAD_BEEF, 4);
        v(1, 0, 32'h0,         32'h0,         0, 1, 4'b1000, 32'h20, 32'hDEAD_BEEF, 4);
        v(1, 1, 32'h5,         32'h0,         0, 1, 4'b0100, 32'h20, 32'h5,         4);
        v(1, 1, 32'h5,         32'h21,        0, 1, 4'b1000, 32'h21, 32'h5,         5);
        v(1, 1, 32'h6,         32'h0,         0, 0, 4'b0100, 32'h21, 32'h6,         5);
        // reset during EXECUTA with count 5: novo_PC must not load
        v(0, 1, 32'h7,         32'h99,        0, 0, 4'b1000, 32'h10, 32'h0,         0);

        for (int i = 0; i < tabela.size(); i++)
            ciclo(tabela[i], $sformatf("vec%0d", i));

        // Timeout: ready held low, trap must appear after exactly 4 BUSCA cycles
        t = tabela[0];
        t.rst = 1'b1; t.pr = 1'b0;
        @(negedge clock);
        drive(t);
        espera = 0;
        while (erro !== 1'b1 && espera < 20) begin
            @(posedge clock);
            #1;
            espera++;
        end
        n_vec++;
        if (espera != 4) begin
            n_erro++;
            $display("FAIL timeout_cycles: got %0d cycles to erro, want 4", espera);
        end
        t.flags = 4'b0001; t.pc = 32'h10; t.inst = 32'h0; t.cnt = 0;
        compara("timeout_state", t);

        // Ready after the trap is ignored
        t.pr = 1'b1; t.dado = 32'h77; t.npc = 32'h44;
        ciclo(t, "erro_ignores_ready");
        ciclo(t, "erro_terminal");

        // Reset leaves the trap
        t.rst = 1'b0; t.flags = 4'b1000;
        ciclo(t, "erro_reset");

        // Fetch resumes normally after reset
        t.rst = 1'b1; t.pr = 1'b1; t.dado = 32'hCAFE; t.flags = 4'b0100; t.inst = 32'hCAFE;
        ciclo(t, "post_trap_fetch");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_erro);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/controle_busca.md
# controle_busca

Fetch sequencer and PC register for the MIPS core. It holds the architectural PC and fetches each instruction from instruction memory using a request/ready handshake. It presents the fetched word for exactly one execute cycle, then loads the next PC from the PC-select multiplexer (`novo_PC`). It also provides halt/resume, a fetch-timeout error trap and a retired-instruction counter.

## Interface
- `PC_INICIAL`, default 32'h0000_0000: PC value loaded at reset.
- `TIMEOUT`, default 255: maximum consecutive BUSCA cycles without `mem_pronto` before trapping. Legal range is 1..65535.

- `clock`, in, 1: single clock. All state changes on the rising edge.
- `reset`, in, 1: synchronous, active-low (0 = reset, sampled on the `clock` rising edge).
- `novo_PC`, in, 32: next-PC value from the PC-select multiplexer, valid during EXECUTA.
- `halt`, in, 1: decoded halt instruction, sampled only in EXECUTA.
- `continuar`, in, 1: resume request, sampled only in PARADO.
- `mem_pronto`, in, 1: instruction memory ready; `mem_dado` is valid in the same cycle.
- `mem_dado`, in, 32: instruction word from memory.
- `PC`, out, 32: current PC register.
- `mem_endereco`, out, 32: fetch address; always equal to `PC`.
- `mem_req`, out, 1: fetch request.
- `instrucao`, out, 32: registered fetched instruction.
- `executa`, out, 1: one-cycle enable for register-file and data-memory writes.
- `parado`, out, 1: core halted.
- `erro`, out, 1: fetch timeout trap.
- `instr_contador`, out, 32: count of retired instructions.

## Operation
- States: BUSCA, EXECUTA, PARADO, ERRO.
- Moore outputs, decoded from the state register only:
  - `mem_req` = 1 only in BUSCA.
  - `executa` = 1 only in EXECUTA.
  - `parado` = 1 only in PARADO.
  - `erro` = 1 only in ERRO.
- Reset (`reset`=0 at an edge) has priority over every transition and takes effect from any state, including mid-fetch and mid-EXECUTA. After the edge:
  - State = BUSCA, `PC` = `PC_INICIAL`.
  - `instrucao` = 0, `instr_contador` = 0, wait counter = 0.
  - Outputs: `mem_req`=1, `executa`=0, `parado`=0, `erro`=0.
- BUSCA:
  - If `mem_pronto`=1: `instrucao` <= `mem_dado`, go to EXECUTA, clear the wait counter.
  - Else, if the wait counter = `TIMEOUT`-1: go to ERRO.
  - Else: increment the wait counter and stay in BUSCA.
- EXECUTA (always lasts exactly one cycle):
  - `PC` <= `novo_PC`.
  - `instr_contador` <= `instr_contador`+1, wrapping 32'hFFFF_FFFF -> 0.
  - Next state is PARADO if `halt`=1, else BUSCA.
- PARADO:
  - If `continuar`=1: go to BUSCA, wait counter = 0.
  - Else: hold. `PC` and `instrucao` are held.
- ERRO: terminal until reset. `PC`, `instrucao` and `instr_contador` are frozen.
- Ignored inputs:
  - `mem_pronto` outside BUSCA.
  - `halt` outside EXECUTA.
  - `continuar` outside PARADO.
- `PC` changes only in EXECUTA or on reset. No arithmetic is done on `PC`; word addressing (+1 steps) is the multiplexer's responsibility.
- `instrucao` changes only on a BUSCA->EXECUTA transition or on reset.

## Timing
- Zero-wait memory: 2 cycles per instruction (BUSCA + EXECUTA).
- N wait cycles: N+2 cycles per instruction.
- `mem_pronto` is sampled in the same cycle as `mem_req`. There is no registered request latency.
- `instrucao` is valid throughout EXECUTA, one cycle after the accepting BUSCA cycle.
- Timeout boundary: the trap fires at the edge ending the `TIMEOUT`-th consecutive BUSCA cycle with `mem_pronto`=0. `mem_pronto`=1 in that same cycle wins, and the fetch completes normally.
- Halt/resume:
  - `parado` rises the cycle after the EXECUTA cycle that sampled `halt`.
  - `mem_req` rises the cycle after `continuar` is sampled.
  - The fetch after resume uses the `PC` already updated with `novo_PC` of the halting instruction.
- `TIMEOUT`=1: any BUSCA cycle without ready traps immediately.

## Test plan
- Reset with `PC_INICIAL`=32'h10, `reset`=0 for 2 cycles, then 1 -> `PC`=32'h10, `mem_req`=1, `executa`=0, `instrucao`=0, `instr_contador`=0.
- `mem_pronto` held 1, `mem_dado`=32'hA, `novo_PC`=`PC`+1 -> `executa` high every 2nd cycle, `PC` steps 32'h10, 32'h11, 32'h12, 32'h13, `instr_contador`=3 after the third EXECUTA.
- `mem_pronto` low for 3 cycles then high with `mem_dado`=32'hDEAD_BEEF -> 4 BUSCA cycles, `instrucao`=32'hDEAD_BEEF during the single EXECUTA cycle, `PC` unchanged until that edge.
- `halt`=1 in EXECUTA with `novo_PC`=32'h20 -> `PC`=32'h20, `parado`=1, `mem_req`=0 and stable for 5 cycles; `continuar`=1 -> next cycle BUSCA with `mem_endereco`=32'h20.
- `TIMEOUT`=4, `mem_pronto`=0 -> `erro`=1 after 4 BUSCA cycles, `mem_req`=0; a later `mem_pronto`=1 is ignored; reset -> BUSCA, `erro`=0. Variant: `mem_pronto`=1 in the 4th cycle -> normal EXECUTA, no trap.
- `reset`=0 during EXECUTA with `instr_contador`=5 -> next cycle `executa`=0, `PC`=`PC_INICIAL`, `instr_contador`=0, and the `novo_PC` presented in that cycle is not loaded.
